// File: rtl/ram_reader.sv
// Block reader for a single-port synchronous RAM: streams LEN words from BASE
// (address wraps mod 2^AW) onto a valid/ready stream with a last flag.
module ram_reader #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] len,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd_en,
    output logic          ram_wr_en,
    input  logic [DW-1:0] ram_d_out,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          busy,
    output logic          done
);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       base_q, base_d;
    logic [CW-1:0]       len_q, len_d;
    logic [CW-1:0]       issue_cnt_q, issue_cnt_d;
    logic [CW-1:0]       out_cnt_q, out_cnt_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic                inflight_q, inflight_d;
    logic [1:0][DW-1:0]  fifo_q, fifo_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          cnt_q, cnt_d;

    logic                pop;
    logic [2:0]          occ;

    assign m_valid = (cnt_q != 2'd0);
    assign pop     = m_valid && m_ready;
    // Occupancy counts the word leaving this cycle, so a full-rate stream keeps
    // issuing while never exceeding two words in flight plus buffered.
    assign occ       = {2'b00, inflight_q} + {1'b0, cnt_q} - {2'b00, pop};
    assign ram_rd_en = (state_q == S_RUN) && (issue_cnt_q < len_q) && (occ < 3'd2);
    assign ram_addr  = ram_rd_en ? (base_q + issue_cnt_q[AW-1:0]) : addr_q;
    assign ram_wr_en = 1'b0;
    assign m_data    = m_valid ? fifo_q[rd_ptr_q] : '0;
    assign m_last    = m_valid && ((out_cnt_q + CW'(1)) == len_q);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        issue_cnt_d = issue_cnt_q;
        out_cnt_d   = out_cnt_q;
        addr_d      = ram_addr;
        inflight_d  = ram_rd_en;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q + {1'b0, inflight_q} - {1'b0, pop};

        if (ram_rd_en)
            issue_cnt_d = issue_cnt_q + CW'(1);
        // RAM data lands one cycle after its address was presented
        if (inflight_q) begin
            fifo_d[wr_ptr_q] = ram_d_out;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d  = ~rd_ptr_q;
            out_cnt_d = out_cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d      = base;
                    len_d       = {1'b0, len};
                    issue_cnt_d = '0;
                    out_cnt_d   = '0;
                    state_d     = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (pop && m_last)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            addr_q      <= '0;
            inflight_q  <= 1'b0;
            fifo_q      <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            issue_cnt_q <= issue_cnt_d;
            out_cnt_q   <= out_cnt_d;
            addr_q      <= addr_d;
            inflight_q  <= inflight_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ram_reader.sv
// Scoreboard bench for ram_reader: a behavioural RAM plus a transfer-level
// reference model that predicts addresses, words, last flags and done timing.
module tb_ram_reader;
    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n, start, m_ready;
    logic [AW-1:0] base, len, ram_addr;
    logic          ram_rd_en, ram_wr_en;
    logic [DW-1:0] ram_d_out, m_data;
    logic          m_valid, m_last, busy, done;

    always #5 clk = ~clk;

    ram_reader #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
        .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en),
        .ram_d_out(ram_d_out), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done)
    );

    logic [DW-1:0] mem [256];
    always @(posedge clk) ram_d_out <= mem[ram_addr];

    typedef struct { logic [DW-1:0] d; logic l; } exp_t;
    exp_t          exp_q[$];
    logic [AW-1:0] addr_exp[$];

    int total = 0, bad = 0, cyc = 0, hs_cnt = 0;
    int exp_done = -10, e0 = 0, cur_len = 0, outst = 0;
    bit act = 0, first_seen = 0, prev_stall = 0, chk_rst = 0;
    logic [DW-1:0] prev_data;
    logic prev_last;
    int ready_mode = 0;
    bit chk_lat = 0;

    task automatic chk(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cyc);
        end
    endtask

    // m_ready patterns: steady, the 1,0,0,1,0,1 toggle, or random
    int rpi = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1: begin
                m_ready = (rpi == 0 || rpi == 3 || rpi == 5);
                rpi = (rpi + 1) % 6;
            end
            2:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b1;
        endcase
    end

    // Monitor + reference model; each negedge represents one clock cycle
    always @(negedge clk) begin
        bit accept;
        exp_t e;
        logic [AW-1:0] a;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            addr_exp.delete();
            act = 0; exp_done = -10; outst = 0; prev_stall = 0; chk_rst = 1;
        end else begin
            if (chk_rst) begin
                chk("rst_addr", ram_addr, 0);
                chk("rst_rd_en", ram_rd_en, 0);
                chk("rst_valid", m_valid, 0);
                chk("rst_last", m_last, 0);
                chk("rst_data", m_data, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk_rst = 0;
            end
            if (m_valid) begin
                if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
                else begin
                    chk("data", m_data, exp_q[0].d);
                    chk("last", m_last, exp_q[0].l);
                    if (!first_seen && chk_lat) chk("first_latency", cyc, e0 + 2);
                    first_seen = 1;
                    if (m_ready) begin
                        if (exp_q[0].l && chk_lat && ready_mode == 0)
                            chk("last_latency", cyc, e0 + cur_len + 1);
                        if (exp_q[0].l) exp_done = cyc + 1;
                        void'(exp_q.pop_front());
                        hs_cnt++;
                        outst--;
                    end
                end
            end
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, prev_data);
                chk("stall_last", m_last, prev_last);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (ram_rd_en) begin
                if (addr_exp.size() == 0) chk("spurious_rd", 1, 0);
                else chk("rd_addr", ram_addr, addr_exp.pop_front());
                outst++;
                chk("outstanding_le2", int'(outst <= 2), 1);
                chk("wr_en_low", ram_wr_en, 0);
            end
            if (done || cyc == exp_done) chk("done", done, int'(cyc == exp_done));
            if (act) chk("busy", busy, 1);
            if (cyc == exp_done + 1) chk("busy_clear", busy, 0);

            accept = start && !act;
            if (cyc == exp_done) begin
                chk("leftover_words", exp_q.size(), 0);
                act = 0;
            end
            if (accept) begin
                act = 1; e0 = cyc + 1; cur_len = int'(len); first_seen = 0;
                if (len == 0) exp_done = cyc + 1;
                for (int i = 0; i < int'(len); i++) begin
                    a = base + AW'(i);
                    addr_exp.push_back(a);
                    e.d = mem[a];
                    e.l = (i == int'(len) - 1);
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] l);
        @(posedge clk); #1;
        start = 1'b1; base = b; len = l;
        @(posedge clk); #1;
        start = 1'b0; base = AW'($urandom); len = AW'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (!act && !busy) return;
        end
        $display("FAIL timeout waiting for idle: busy=%0d model_active=%0d", busy, act);
        $fatal(1, "timeout");
    endtask

    initial begin
        int target;
        int r;
        logic [AW-1:0] l;
        rst_n = 1'b0; start = 1'b0; base = '0; len = '0;
        for (int i = 0; i < 256; i++) mem[i] = DW'(i) ^ 8'hA5;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk_lat = 1;
        do_start(8'h10, 8'd4); wait_idle();
        chk_lat = 0; ready_mode = 1;
        do_start(8'h10, 8'd4); wait_idle();
        ready_mode = 0; chk_lat = 1;
        do_start(8'hFE, 8'd4); wait_idle();
        chk_lat = 0;
        do_start(8'h00, 8'd0); wait_idle();

        // reset one edge after the third handshake of a len=8 transfer
        target = hs_cnt + 3;
        do_start(8'h20, 8'd8);
        for (int i = 0; i < 200 && hs_cnt < target; i++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        do_start(8'h00, 8'd2); wait_idle();

        // a start during a transfer is ignored; one right after done is taken
        do_start(8'h10, 8'd4);
        @(posedge clk); #1 start = 1'b1; base = 8'h80; len = 8'd4;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1 start = 1'b1; base = 8'h30; len = 8'd3;
        @(posedge clk); #1 start = 1'b0;
        wait_idle();

        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
        for (int t = 0; t < 25; t++) begin
            ready_mode = $urandom_range(0, 2);
            r = $urandom_range(0, 9);
            if (r == 0) l = 8'd0;
            else if (r == 1) l = 8'd1;
            else if (t == 12) l = 8'd255;
            else l = AW'($urandom_range(1, 40));
            do_start(AW'($urandom), l);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_reader.md
Name: ram_reader

Overview:
- Read-side companion to the single-port synchronous RAM (clk, wr_en, d_in, addr, d_out; registered read, 1-cycle latency).
- On a start pulse, reads a contiguous block of LEN words beginning at BASE, wrapping modulo 2^AW.
- Streams the words out on a valid/ready interface with a last flag, sustaining one word per cycle when the sink is ready.
- Sits between the RAM and any consumer: DMA-style drain, packet playback, scan-out.

Parameters:
DW, 8, data width (matches RAM d_out)
AW, 8, address width (matches RAM addr)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous reset, active low
start  in  1  one-cycle request; sampled only in IDLE
base  in  AW  first address; captured when start is accepted
len  in  AW  word count, 0..2^AW-1; captured with base; 0 = empty transfer
ram_addr  out  AW  address to RAM addr port
ram_rd_en  out  1  high when ram_addr is a real read issue (debug/power; RAM reads unconditionally)
ram_wr_en  out  1  tied 0; reader never writes
ram_d_out  in  DW  RAM read data; valid the cycle after the address is presented
m_data  out  DW  stream data
m_valid  out  1  stream valid
m_ready  in  1  stream ready from sink
m_last  out  1  high with the final word of a transfer
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when the transfer completes

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE. ram_addr=0, ram_rd_en=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0, issue and output counters=0, buffer empty. Reset overrides every other input. Reset mid-transfer aborts silently: no done pulse, and in-flight read data is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 with len!=0: capture base/len, go RUN, busy=1 next cycle.
  - start=1 with len=0: go DONE directly, busy=1 for one cycle, no m_valid ever.
  - start=0: stay in IDLE.
- RUN, issue side:
  - ram_addr = base + issue_cnt, computed mod 2^AW. Wrap 2^AW-1 -> 0 with no error.
  - A read is issued in a cycle (ram_rd_en=1) only when issue_cnt < len and credits > 0.
  - credits = 2 - (reads in flight + words held in the output buffer).
  - Data for a read issued in cycle N is written into the 2-entry output buffer at the end of cycle N+1.
- RUN, output side:
  - m_valid=1 whenever the buffer is non-empty. m_data = head entry.
  - A handshake (m_valid & m_ready) pops the head and increments out_cnt.
  - m_data and m_last must hold stable while m_valid=1 and m_ready=0.
  - m_last=1 exactly when the head word is word index len-1.
  - Simultaneous push and pop in one cycle is legal; occupancy is unchanged.
- Latency and throughput:
  - start accepted at edge E0. First ram_rd_en at cycle after E0 (addr=base). First m_valid=1 two cycles after E0.
  - With m_ready held high: one word per cycle, no bubbles, last word at E0+len+1.
  - With m_ready low: at most 2 reads outstanding, so no word is ever lost or overwritten.
- RUN -> DONE on the handshake of the last word (out_cnt reaches len).
- DONE: done=1 for exactly one cycle, busy=0 next cycle, return to IDLE. A new start is accepted in the cycle after DONE.
- start while busy (RUN or DONE) is ignored; base/len are not re-captured.
- ram_rd_en=0 and ram_addr holds its last value whenever no read is issued.
- Counters are AW+1 bits wide to avoid overflow at len=2^AW-1.

Test Plan:
1. Preload RAM[a]=a^8'hA5. base=0x10, len=4, m_ready=1 -> m_data A5^10, A5^11, A5^12, A5^13 (B5, B4, B7, B6) on 4 consecutive cycles starting 2 cycles after start; m_last only on B6; done pulse the cycle after B6; busy high throughout.
2. Same transfer, m_ready toggling 1,0,0,1,0,1,... -> identical data sequence; no duplicates or drops; m_data stable while stalled; ram_rd_en never leaves more than 2 words in flight plus buffered.
3. base=0xFE, len=4 -> ram_addr sequence FE, FF, 00, 01; data 5B, 5A, A5, A4; m_last on A4.
4. len=0, start=1 -> busy for 1 cycle, done pulse, m_valid and ram_rd_en never asserted.
5. base=0x20, len=8, rst_n=0 for one edge after the 3rd handshake -> all outputs at reset values next cycle, no done pulse. A fresh start (base=0x00, len=2) then returns A5, A4 correctly.
6. start pulsed again with base=0x80 during a len=4 transfer -> ignored; original 4 words emitted. A start one cycle after done is accepted.
